// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing with mem_ready wait states. Define ILLEGAL_OP_TRAP_EN to trap unrecognised opcodes.
module multicycle_control #(
    parameter int USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic       illegal_op,
`endif
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_reg;
    state_t state_next;
    logic   ready;

    // Decoded controls before the reset gating of the write-type enables.
    logic       pc_write_dec;
    logic       pc_write_cond_dec;
    logic       mem_write_dec;
    logic       ir_write_dec;
    logic       reg_write_dec;
    logic       instr_done_dec;
    logic       iord_dec;
    logic       mem_read_dec;
    logic       mem_to_reg_dec;
    logic       reg_dst_dec;
    logic       alu_src_a_dec;
    logic [1:0] alu_src_b_dec;
    logic [1:0] alu_op_dec;
    logic [1:0] pc_source_dec;
    logic       illegal_dec;

    assign ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next        = S_FETCH;
        pc_write_dec      = 1'b0;
        pc_write_cond_dec = 1'b0;
        mem_write_dec     = 1'b0;
        ir_write_dec      = 1'b0;
        reg_write_dec     = 1'b0;
        instr_done_dec    = 1'b0;
        iord_dec          = 1'b0;
        mem_read_dec      = 1'b0;
        mem_to_reg_dec    = 1'b0;
        reg_dst_dec       = 1'b0;
        alu_src_a_dec     = 1'b0;
        alu_src_b_dec     = 2'b00;
        alu_op_dec        = 2'b00;
        pc_source_dec     = 2'b00;
        illegal_dec       = 1'b0;

        case (state_reg)
            S_FETCH: begin
                mem_read_dec  = 1'b1;
                alu_src_b_dec = 2'b01;
                ir_write_dec  = ready;
                pc_write_dec  = ready;
                state_next    = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b_dec = 2'b11;
                case (opcode)
                    OP_RTYPE:      state_next = S_EXEC;
                    OP_LW, OP_SW:  state_next = S_MEMADR;
                    OP_BEQ:        state_next = S_BRANCH;
                    OP_J:          state_next = S_JUMP;
                    OP_ADDI:       state_next = S_ADDIEX;
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        state_next = S_TRAP;
`else
                        // Unknown opcode retires as a two-cycle NOP.
                        state_next     = S_FETCH;
                        instr_done_dec = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_dec = 1'b1;
                alu_src_b_dec = 2'b10;
                state_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read_dec = 1'b1;
                iord_dec     = 1'b1;
                state_next   = ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg_dec = 1'b1;
                reg_write_dec  = 1'b1;
                instr_done_dec = 1'b1;
            end
            S_MEMWR: begin
                // The write strobe is held across wait states; the store retires on ready.
                mem_write_dec  = 1'b1;
                iord_dec       = 1'b1;
                instr_done_dec = ready;
                state_next     = ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a_dec = 1'b1;
                alu_op_dec    = 2'b10;
                state_next    = S_RWB;
            end
            S_RWB: begin
                reg_dst_dec    = 1'b1;
                reg_write_dec  = 1'b1;
                instr_done_dec = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_dec     = 1'b1;
                alu_op_dec        = 2'b01;
                pc_write_cond_dec = 1'b1;
                pc_source_dec     = 2'b01;
                instr_done_dec    = 1'b1;
            end
            S_JUMP: begin
                pc_write_dec   = 1'b1;
                pc_source_dec  = 2'b10;
                instr_done_dec = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a_dec = 1'b1;
                alu_src_b_dec = 2'b10;
                state_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_dec  = 1'b1;
                instr_done_dec = 1'b1;
            end
            S_TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
                // Parked with every enable low until reset.
                illegal_dec = 1'b1;
                state_next  = S_TRAP;
`else
                state_next  = S_FETCH;
`endif
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Reset parks the register in FETCH; write-type enables are additionally
    // gated by rst_n so nothing commits while reset is held.
    assign PCWrite     = pc_write_dec & rst_n;
    assign PCWriteCond = pc_write_cond_dec & rst_n;
    assign MemWrite    = mem_write_dec & rst_n;
    assign IRWrite     = ir_write_dec & rst_n;
    assign RegWrite    = reg_write_dec & rst_n;
    assign instr_done  = instr_done_dec & rst_n;
    assign IorD        = iord_dec;
    assign MemRead     = mem_read_dec;
    assign MemtoReg    = mem_to_reg_dec;
    assign RegDst      = reg_dst_dec;
    assign ALUSrcA     = alu_src_a_dec;
    assign ALUSrcB     = alu_src_b_dec;
    assign ALUOp       = alu_op_dec;
    assign PCSource    = pc_source_dec;
    assign state       = state_reg;
`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal_op  = illegal_dec;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_dec;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed reset/trap steps plus random instruction
// streams with random memory wait states, checked against a per-instruction path model.
module tb_multicycle_control;

    localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, EX = 6;
    localparam int RWB = 7, BR = 8, J = 9, AE = 10, AW = 11, TR = 12;

`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal_op;
`endif

    int errors = 0;
    int checks = 0;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] outs();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done};
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        return op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 || op == 6'd2 || op == 6'd8;
    endfunction

    // Expected control word for a state, from the per-state output table.
    function automatic logic [16:0] exp_out(int st, logic rdy, logic [5:0] op);
        logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0;
        logic rd = 0, rw = 0, asa = 0, done = 0;
        logic [1:0] asb = 0, aop = 0, pcs = 0;
        case (st)
            F:   begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            D:   begin asb = 2'b11; done = !is_legal(op) && !TRAP_EN; end
            MA:  begin asa = 1; asb = 2'b10; end
            MR:  begin mr = 1; iord = 1; end
            MWB: begin m2r = 1; rw = 1; done = 1; end
            MW:  begin mw = 1; iord = 1; done = rdy; end
            EX:  begin asa = 1; aop = 2'b10; end
            RWB: begin rd = 1; rw = 1; done = 1; end
            BR:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            J:   begin pcw = 1; pcs = 2'b10; done = 1; end
            AE:  begin asa = 1; asb = 2'b10; end
            AW:  begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected per-cycle trace of one instruction: state and forced mem_ready (-1 = random).
    int path[$];
    int mrq[$];

    task automatic add_wait(input int st, input int n);
        for (int i = 0; i < n; i++) begin path.push_back(st); mrq.push_back(0); end
        path.push_back(st); mrq.push_back(1);
    endtask

    task automatic add(input int st);
        path.push_back(st); mrq.push_back(-1);
    endtask

    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        logic rdy;
        path.delete(); mrq.delete();
        add_wait(F, wf);
        add(D);
        case (op)
            6'd0:  begin add(EX); add(RWB); end
            6'd35: begin add(MA); add_wait(MR, wm); add(MWB); end
            6'd43: begin add(MA); add_wait(MW, wm); end
            6'd4:  add(BR);
            6'd2:  add(J);
            6'd8:  begin add(AE); add(AW); end
            default: ;
        endcase
        for (int k = 0; k < path.size(); k++) begin
            @(negedge clk);
            opcode = (path[k] == F) ? 6'($urandom) : op;
            rdy = (mrq[k] < 0) ? 1'($urandom) : 1'(mrq[k]);
            mem_ready = rdy;
            #1;
            check($sformatf("op%0d c%0d state", op, k), 32'(state), 32'(path[k]));
            check($sformatf("op%0d c%0d outs", op, k), 32'(outs()), 32'(exp_out(path[k], rdy, op)));
        end
        @(posedge clk); #1;
        check($sformatf("op%0d refetch", op), 32'(state), 32'(F));
        $display("instr op=%06b wait_fetch=%0d wait_mem=%0d cycles=%0d", op, wf, wm, path.size());
    endtask

    logic [5:0] legal_ops [6] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8};

    initial begin
        logic [5:0] op;
        rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset state", 32'(state), 32'(F));
        check("reset outs", 32'(outs()), 32'(exp_out(F, 1'b0, 6'd0)));

        // sw, then reset asserted mid-MEMWR while the write strobe is high.
        @(negedge clk); rst_n = 1'b1; opcode = 6'd43; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("sw memwr state", 32'(state), 32'(MW));
        check("sw memwr strobe", 32'(MemWrite), 32'd1);
        #2 rst_n = 1'b0; mem_ready = 1'b1; #1;
        check("abort MemWrite", 32'(MemWrite), 32'd0);
        check("abort state", 32'(state), 32'(F));
        check("abort IRWrite gated", 32'(IRWrite), 32'd0);
        @(negedge clk); rst_n = 1'b1; opcode = 6'd2; #1;
        check("release IRWrite", 32'(IRWrite), 32'd1);
        @(posedge clk); #1;
        check("release decode", 32'(state), 32'(D));
        @(negedge clk); @(negedge clk); #1;
        check("j after release", 32'(state), 32'(J));
        @(posedge clk); #1;
        $display("reset abort sequence done");

        // Directed plan items, then a random instruction stream.
        run_instr(6'd35, 0, 0);
        run_instr(6'd43, 0, 3);
        run_instr(6'd0, 0, 0);
        run_instr(6'd4, 0, 0);
        run_instr(6'd2, 0, 0);
        run_instr(6'd8, 2, 0);
        for (int n = 0; n < 80; n++) begin
            if (!TRAP_EN && $urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 5)];
            end
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

`ifdef ILLEGAL_OP_TRAP_EN
        @(negedge clk); opcode = 6'b111111; mem_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); mem_ready = 1'($urandom); opcode = 6'($urandom); #1;
            check($sformatf("trap c%0d state", k), 32'(state), 32'(TR));
            check($sformatf("trap c%0d illegal_op", k), 32'(illegal_op), 32'd1);
            check($sformatf("trap c%0d outs", k), 32'(outs()), 32'd0);
        end
        $display("trap held 20 cycles");
`else
        run_instr(6'b111111, 1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath select and enable: the mux selects, the memory strobes, and the PC and register write enables.
- Inserts wait states on memory accesses using a ready handshake.

Parameters:
USE_MEM_READY, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1 (single-cycle memory)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  instruction bits [31:26] from the instruction register
mem_ready  input  1  memory completed the current read/write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU Zero (beq)
IorD  output  1  address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
MemtoReg  output  1  write-back select: 0 = ALUOut, 1 = MDR
RegDst  output  1  destination register: 0 = rt, 1 = rd
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A operand: 0 = PC, 1 = register A
ALUSrcB  output  2  ALU B operand: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm << 2
ALUOp  output  2  00 = add, 01 = sub, 10 = use funct field
PCSource  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
instr_done  output  1  one-cycle pulse in the last state of each instruction
state  output  4  current state encoding, for debug

Behaviour:
- Clock, reset and output timing:
  - Single clock, asynchronous active-low reset.
  - State register is the only storage. rst_n low puts it in FETCH immediately.
  - Outputs are decoded combinationally from state. The only exception is gating by mem_ready and rst_n.
  - Any output not listed for a state is 0.
- Reset:
  - While rst_n = 0, PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite and instr_done are forced to 0.
  - The other outputs show FETCH values: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - Reset asserted in any state aborts the instruction. There is no partial write after the abort edge.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12.
- Per-state outputs and transitions:
  - FETCH:
    - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
    - IRWrite=PCWrite=mem_ready.
    - Goes to DECODE when mem_ready=1, else holds.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
    - 000000 -> EXEC
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDIEX
    - any other -> see Optional Feature
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw. Opcode is re-sampled here; IR is stable.
  - MEMRD: MemRead=1, IorD=1. Goes to MEMWB on mem_ready, else holds.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Goes to FETCH.
  - MEMWR: MemWrite=1, IorD=1.
    - MemWrite stays high while waiting.
    - On mem_ready, instr_done=1 and goes to FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RWB.
  - RWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Goes to FETCH.
  - JUMP: PCWrite=1, PCSource=10, instr_done=1. Goes to FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
- Latency with mem_ready held at 1, counting from FETCH entry to FETCH re-entry:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
  - Each cycle mem_ready is low adds one cycle in FETCH, MEMRD or MEMWR.
- Handshake rules:
  - mem_ready is sampled only in FETCH, MEMRD and MEMWR; in all other states it is ignored.
  - Strobes stay asserted until ready is seen. A mem_ready pulse arriving early has no effect.
- Unused state codes 13–15 go to FETCH on the next edge with all outputs 0.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - An unrecognised opcode in DECODE goes to TRAP.
  - TRAP drives all enables to 0 and holds until rst_n is asserted.
  - An extra output port illegal_op (1 bit) is 1 only in TRAP.
- Undefined:
  - An unrecognised opcode goes DECODE -> FETCH, treated as a 2-cycle NOP.
  - instr_done pulses in DECODE.
  - No illegal_op port, and TRAP is unreachable.

Test Plan:
- Reset: drop rst_n mid-MEMWR with MemWrite=1 -> MemWrite=0 immediately, state=0. Release -> FETCH, IRWrite=1 on the first edge with mem_ready=1.
- lw, opcode=100011, mem_ready=1 -> state sequence 0,1,2,3,4 then 0.
  - In MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - instr_done high exactly one cycle.
- sw with mem_ready low 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then FETCH. Total 7 cycles.
- R-type opcode=000000 -> EXEC with ALUOp=10, ALUSrcB=00, then RWB with RegDst=1, RegWrite=1. 4 cycles.
- beq opcode=000100 -> BRANCH with PCWriteCond=1, PCSource=01, ALUOp=01, PCWrite=0. j opcode=000010 -> JUMP with PCWrite=1, PCSource=10. Both 3 cycles.
- opcode=111111:
  - With ILLEGAL_OP_TRAP_EN: state=12, illegal_op=1, held for 20 cycles.
  - Without it: back to FETCH after DECODE, no write enable asserted.
